div_restoring_16bit: RTL and testbench

Multi-cycle unsigned 16-bit divider for the non-pipelined MIPS datapath. It provides the inverse of the ripple adder, so DIVU uses a repeated shift-and-subtract core. The block takes a dividend and divisor on a start pulse and runs one restoring iteration per clock. It returns quotient and remainder with a one-cycle done pulse. The ALU controller stalls on busy and reads results into HI/LO on done.

---
 rtl/alu_pkg.sv | 15 +
 rtl/div_step.sv | 22 ++
 rtl/div_restoring_16bit.sv | 120 ++++++++++++
 tb/tb_div_restoring_16bit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider width, divider FSM states, iteration counter width.
// No logic; types and constants only.
// Consumers import with alu_pkg::*.
package alu_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of D from the shifted partial remainder.
// Purely combinational, zero cycles.
// No flow control; the caller decides when the result is registered.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   r_shifted,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // Subtract at WIDTH+1 bits so the top bit is a clean borrow; keep the trial only if no borrow.
  always_comb begin
    trial  = r_shifted - {1'b0, d};
    q_bit  = ~trial[WIDTH];
    r_next = q_bit ? trial : r_shifted;
  end

endmodule

// File: rtl/div_restoring_16bit.sv
// Unsigned restoring divider: quotient/remainder from dividend/divisor, one bit per clock.
// Latency WIDTH+1 cycles from accepted start to done (1 cycle for divide-by-zero).
// No backpressure: start is ignored while busy; results are held until the next accepted start.
module div_restoring_16bit
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int                CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  div_state_e       state, state_nxt;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   r_part;
  logic [WIDTH-1:0] d_reg;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             div_zero_in;
  logic [WIDTH:0]   r_shifted;
  logic [WIDTH:0]   r_step;
  logic             q_bit;
  logic [WIDTH-1:0] q_step;

  // A new operation is taken whenever the core is not iterating.
  assign accept      = start && (state != S_RUN);
  assign div_zero_in = (divisor == '0);

  // Shift {R,Q} left by one; the quotient MSB feeds the remainder LSB.
  assign r_shifted = (r_part << 1) | {{WIDTH{1'b0}}, q_sh[WIDTH-1]};
  assign q_step    = {q_sh[WIDTH-2:0], q_bit};

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_shifted (r_shifted),
    .d         (d_reg),
    .r_next    (r_step),
    .q_bit     (q_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: DONE behaves like IDLE so a start there runs back-to-back.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = div_zero_in ? S_DONE : S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (count == LAST) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one iteration per RUN cycle, result capture on the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_sh        <= '0;
      r_part      <= '0;
      d_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (div_zero_in) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        q_sh        <= dividend;
        r_part      <= '0;
        d_reg       <= divisor;
        count       <= '0;
        div_by_zero <= 1'b0;
      end
    end else if (state == S_RUN) begin
      q_sh   <= q_step;
      r_part <= r_step;
      count  <= count + 1'b1;
      if (count == LAST) begin
        quotient  <= q_step;
        remainder <= r_step[WIDTH-1:0];
      end
    end
  end

  // Moore status outputs decoded from the state register only.
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_div_restoring_16bit.sv
module tb_div_restoring_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_restoring_16bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: results from / and %, timing as "16 busy cycles then a done cycle".
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_q = '0, m_r = '0;
  logic        m_dbz = 1'b0;
  logic [15:0] p_q = '0, p_r = '0;
  logic [15:0] op_a = '0, op_b = '0;
  bit          chk_on = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_dbz = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_done) begin
        m_q = p_q;
        m_r = p_r;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        op_a = dividend;
        op_b = divisor;
        if (divisor == 16'd0) begin
          m_q = 16'hFFFF; m_r = dividend; m_dbz = 1'b1; m_done = 1'b1;
        end else begin
          p_q = dividend / divisor;
          p_r = dividend % divisor;
          m_dbz  = 1'b0;
          m_left = 16;
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus the arithmetic invariant on each result.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("quotient", 32'(quotient), 32'(m_q));
      chk("remainder", 32'(remainder), 32'(m_r));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
      if (done && !div_by_zero && op_b != 16'd0) begin
        chk("invariant", 32'(quotient) * 32'(op_b) + 32'(remainder), 32'(op_a));
        chk("rem_lt_div", 32'(remainder < op_b), 32'd1);
      end
    end
  end

  task automatic wait_done(input int limit, output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      start    = 1'b0;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
      if (busy) nbusy++;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat, output int nbusy);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    wait_done(40, lat, nbusy);
  endtask

  task automatic expect_res(input string name, input int lat, input int nbusy,
                            input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                            input int elat, input int ebusy);
    chk({name, "_q"}, 32'(quotient), 32'(eq));
    chk({name, "_r"}, 32'(remainder), 32'(er));
    chk({name, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    chk({name, "_lat"}, 32'(lat), 32'(elat));
    chk({name, "_busy"}, 32'(nbusy), 32'(ebusy));
  endtask

  initial begin
    int lat, nb;
    bit seen;
    logic [15:0] a, b;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    run_op(16'd100, 16'd7, lat, nb);      expect_res("d100_7", lat, nb, 16'd14, 16'd2, 1'b0, 17, 16);
    run_op(16'hFFFF, 16'h0001, lat, nb);  expect_res("dffff_1", lat, nb, 16'hFFFF, 16'h0000, 1'b0, 17, 16);
    @(negedge clk);
    run_op(16'd3, 16'd10, lat, nb);       expect_res("d3_10", lat, nb, 16'd0, 16'd3, 1'b0, 17, 16);
    run_op(16'h8000, 16'hFFFF, lat, nb);  expect_res("d8000_ffff", lat, nb, 16'h0000, 16'h8000, 1'b0, 17, 16);
    @(negedge clk);
    run_op(16'd5, 16'd0, lat, nb);        expect_res("d5_0", lat, nb, 16'hFFFF, 16'd5, 1'b1, 1, 0);
    @(negedge clk);

    // Start pulsed mid-RUN must be ignored; then back-to-back start in the DONE cycle.
    start = 1'b1; dividend = 16'd50; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 16'd9; divisor = 16'd2;
    wait_done(40, lat, nb);
    expect_res("d50_3", lat, nb, 16'd16, 16'd2, 1'b0, 13, 12);
    run_op(16'd9, 16'd2, lat, nb);        expect_res("d9_2_b2b", lat, nb, 16'd4, 16'd1, 1'b0, 17, 16);

    // Synchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 16'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_r", 32'(remainder), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op(16'd1000, 16'd9, lat, nb);     expect_res("d1000_9", lat, nb, 16'd111, 16'd1, 1'b0, 17, 16);

    // Random sweep: zero divisors, dividend < divisor, and unconstrained pairs.
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 7))
        0: begin a = 16'($urandom); b = 16'd0; end
        1: begin b = 16'($urandom_range(1, 65535)); a = 16'($urandom_range(0, int'(b) - 1)); end
        2: begin a = 16'($urandom); b = 16'($urandom_range(1, 15)); end
        default: begin a = 16'($urandom); b = 16'($urandom); end
      endcase
      run_op(a, b, lat, nb);
      chk("rand_lat", 32'(lat), (b == 16'd0) ? 32'd1 : 32'd17);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
